// File: rtl/hilo_sched_if.sv
// Signal bundle between the E-stage HI/LO controller and its neighbours
// (E-stage issue/read side, external pipelined multiplier, iterative divider).
interface hilo_sched_if;
  logic        flush;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_ready;
  logic        busy;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_stall;
  logic        res_valid;
  logic [31:0] res_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_start;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        div_abort;

  modport slave (
    input  flush, op_valid, op_type, op_a, op_b, rd_req, rd_sel,
           mul_result, div_done, div_quot, div_rem,
    output op_ready, busy, rd_data, rd_stall, res_valid, res_data, hi, lo,
           mul_start, mul_signed, mul_a, mul_b,
           div_start, div_signed, div_a, div_b, div_abort
  );

  modport master (
    output flush, op_valid, op_type, op_a, op_b, rd_req, rd_sel,
           mul_result, div_done, div_quot, div_rem,
    input  op_ready, busy, rd_data, rd_stall, res_valid, res_data, hi, lo,
           mul_start, mul_signed, mul_a, mul_b,
           div_start, div_signed, div_a, div_b, div_abort
  );
endinterface

// File: rtl/hilo_sched.sv
// HI/LO register owner and multiply/divide sequencer for the execute stage.
// One op in flight at a time; flush cancels it, readers stall while busy.
module hilo_sched #(
  parameter int MUL_LAT = 3
) (
  input  logic        Clk,
  input  logic        Clr,
  hilo_sched_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [3:0] LAT      = 4'(MUL_LAT);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [2:0]  op_reg, op_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        res_valid_reg, res_valid_next;
  logic [31:0] res_data_reg, res_data_next;
  logic        acc;
  logic        mul_go, mul_sgn, div_go, div_sgn, abort;

  assign acc = bus.op_valid && (state_reg == IDLE) && !bus.flush;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_next        = op_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    res_valid_next = 1'b0;
    res_data_next  = res_data_reg;
    mul_go         = 1'b0;
    mul_sgn        = 1'b0;
    div_go         = 1'b0;
    div_sgn        = 1'b0;
    abort          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (acc) begin
          case (bus.op_type)
            OP_MULT, OP_MULTU, OP_MUL: begin
              mul_go     = 1'b1;
              mul_sgn    = (bus.op_type != OP_MULTU);
              cnt_next   = 4'd1;
              op_next    = bus.op_type;
              state_next = MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero completes immediately with HI/LO untouched.
              if (bus.op_b != 32'd0) begin
                div_go     = 1'b1;
                div_sgn    = (bus.op_type == OP_DIV);
                state_next = DIV_WAIT;
              end
            end
            OP_MTHI: hi_next = bus.op_a;
            OP_MTLO: lo_next = bus.op_a;
            default: ;
          endcase
        end
      end
      MUL_WAIT: begin
        if (bus.flush) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg == LAT) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
          if (op_reg == OP_MUL) begin
            res_data_next  = bus.mul_result[31:0];
            res_valid_next = 1'b1;
          end else begin
            {hi_next, lo_next} = bus.mul_result;
          end
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      DIV_WAIT: begin
        // Flush beats a coincident div_done; the result is dropped.
        if (bus.flush) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (bus.div_done) begin
          lo_next    = bus.div_quot;
          hi_next    = bus.div_rem;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      op_reg        <= 3'd0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
    end
  end

  assign bus.op_ready   = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.rd_data    = bus.rd_sel ? hi_reg : lo_reg;
  assign bus.rd_stall   = bus.rd_req && (state_reg != IDLE);
  assign bus.res_valid  = res_valid_reg;
  assign bus.res_data   = res_data_reg;
  assign bus.hi         = hi_reg;
  assign bus.lo         = lo_reg;
  assign bus.mul_start  = mul_go;
  assign bus.mul_signed = mul_sgn;
  assign bus.mul_a      = bus.op_a;
  assign bus.mul_b      = bus.op_b;
  assign bus.div_start  = div_go;
  assign bus.div_signed = div_sgn;
  assign bus.div_a      = bus.op_a;
  assign bus.div_b      = bus.op_b;
  assign bus.div_abort  = abort;

endmodule

// File: tb/tb_hilo_sched.sv
// Directed bench for hilo_sched with behavioural multiplier/divider models;
// expected HI/LO/result values are queued at issue and popped at completion.
module tb_hilo_sched;
  localparam int LAT = 3;

  logic Clk = 1'b0;
  logic Clr;
  always #5 Clk = ~Clk;

  hilo_sched_if bus ();
  hilo_sched #(.MUL_LAT(LAT)) dut (.Clk(Clk), .Clr(Clr), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
    logic        chk_res;
  } exp_t;
  exp_t sb[$];

  // Pipelined multiplier: product appears LAT cycles after mul_start, garbage otherwise.
  logic [63:0] mp_d [LAT];
  logic        mp_v [LAT];

  function automatic logic [63:0] mul_model(logic s, logic [31:0] a, logic [31:0] b);
    if (s) return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return {32'd0, a} * {32'd0, b};
  endfunction

  always @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      for (int i = 0; i < LAT; i++) mp_v[i] <= 1'b0;
    end else begin
      mp_v[0] <= bus.mul_start;
      mp_d[0] <= mul_model(bus.mul_signed, bus.mul_a, bus.mul_b);
      for (int i = 1; i < LAT; i++) begin
        mp_v[i] <= mp_v[i-1];
        mp_d[i] <= mp_d[i-1];
      end
    end
  end
  assign bus.mul_result = mp_v[LAT-1] ? mp_d[LAT-1] : 64'hDEAD_BEEF_BAAD_F00D;

  // Iterative divider: div_done after div_delay cycles unless aborted.
  int          dv_cnt;
  int          div_delay;
  logic [31:0] dq, dr;
  logic        stray_done;

  always @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      dv_cnt <= 0;
    end else if (bus.div_abort) begin
      dv_cnt <= 0;
    end else if (bus.div_start) begin
      dv_cnt <= div_delay;
      if (bus.div_signed) begin
        dq <= $signed(bus.div_a) / $signed(bus.div_b);
        dr <= $signed(bus.div_a) % $signed(bus.div_b);
      end else begin
        dq <= bus.div_a / bus.div_b;
        dr <= bus.div_a % bus.div_b;
      end
    end else if (dv_cnt != 0) begin
      dv_cnt <= dv_cnt - 1;
    end
  end
  assign bus.div_done = (dv_cnt == 1) || stray_done;
  assign bus.div_quot = stray_done ? 32'hBAD0_BAD0 : dq;
  assign bus.div_rem  = stray_done ? 32'hBAD1_BAD1 : dr;

  // Event monitors, sampled mid-cycle.
  int   res_pulses = 0, mul_starts = 0, div_starts = 0, aborts = 0;
  logic last_mul_signed = 1'b0, last_div_signed = 1'b0;
  always @(negedge Clk) begin
    if (bus.res_valid) res_pulses++;
    if (bus.div_abort) aborts++;
    if (bus.mul_start) begin mul_starts++; last_mul_signed = bus.mul_signed; end
    if (bus.div_start) begin div_starts++; last_div_signed = bus.div_signed; end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_hl(input string tag, input logic [31:0] h, input logic [31:0] l,
                           input logic [31:0] r, input logic cr);
    exp_t e;
    e.tag = tag; e.hi = h; e.lo = l; e.res = r; e.chk_res = cr;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_hi"}, bus.hi, e.hi);
      chk({e.tag, "_lo"}, bus.lo, e.lo);
      if (e.chk_res) chk({e.tag, "_res"}, bus.res_data, e.res);
    end
  endtask

  task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b, input string tag);
    bus.op_valid = 1'b1;
    bus.op_type  = t;
    bus.op_a     = a;
    bus.op_b     = b;
    #1;
    chk({tag, "_ready"}, bus.op_ready, 1);
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n, output int stalls);
    n = 0;
    stalls = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      if (bus.rd_stall) stalls++;
      tick();
    end
  endtask

  int n, s, rp, ds;

  initial begin
    Clr = 1'b1;
    bus.flush = 0; bus.op_valid = 0; bus.op_type = 0; bus.op_a = 0; bus.op_b = 0;
    bus.rd_req = 0; bus.rd_sel = 0;
    stray_done = 0; div_delay = 33;
    tick(); tick();
    chk("rst_op_ready", bus.op_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_starts", {bus.mul_start, bus.div_start, bus.div_abort, bus.rd_stall}, 0);
    Clr = 1'b0;
    tick();

    // MTHI then MFHI next cycle, MTLO then MFLO
    expect_hl("mthi", 32'h1234_5678, 32'h0, 0, 0);
    issue(3'd4, 32'h1234_5678, 32'h0, "mthi");
    bus.rd_req = 1; bus.rd_sel = 1; #1;
    chk("mfhi_stall", bus.rd_stall, 0);
    chk("mfhi_data", bus.rd_data, 32'h1234_5678);
    bus.rd_req = 0;
    pop_check();
    tick();
    expect_hl("mtlo", 32'h1234_5678, 32'h0BAD_CAFE, 0, 0);
    issue(3'd5, 32'h0BAD_CAFE, 32'h0, "mtlo");
    bus.rd_req = 1; bus.rd_sel = 0; #1;
    chk("mflo_data", bus.rd_data, 32'h0BAD_CAFE);
    bus.rd_req = 0;
    pop_check();
    tick();

    // MULT -2 * 3 with a concurrent MFLO
    expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0);
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, "mult");
    bus.rd_req = 1; bus.rd_sel = 0; #1;
    chk("mult_stalled_data", bus.rd_data, 32'h0BAD_CAFE);
    wait_idle(n, s);
    chk("mult_busy_cycles", n, LAT);
    chk("mult_stall_cycles", s, LAT);
    chk("mult_unstall", bus.rd_stall, 0);
    chk("mult_mflo", bus.rd_data, 32'hFFFF_FFFA);
    bus.rd_req = 0;
    pop_check();
    chk("mult_signed", last_mul_signed, 1);
    chk("mult_no_res", res_pulses, 0);
    tick();

    // MUL 7*6 -> GPR result pulse, HI/LO untouched
    expect_hl("mul", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd42, 1);
    issue(3'd6, 32'd7, 32'd6, "mul");
    wait_idle(n, s);
    chk("mul_busy_cycles", n, LAT);
    chk("mul_res_valid", bus.res_valid, 1);
    pop_check();
    tick();
    chk("mul_res_pulse_end", bus.res_valid, 0);
    chk("mul_res_pulses", res_pulses, 1);

    // MULTU 0xFFFFFFFE * 3 unsigned
    expect_hl("multu", 32'h2, 32'hFFFF_FFFA, 0, 0);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, "multu");
    wait_idle(n, s);
    pop_check();
    chk("multu_signed", last_mul_signed, 0);
    tick();

    // DIVU 100/7, 33-cycle divider
    div_delay = 33;
    expect_hl("divu", 32'd2, 32'd14, 0, 0);
    issue(3'd3, 32'd100, 32'd7, "divu");
    wait_idle(n, s);
    chk("divu_busy_cycles", n, 33);
    pop_check();
    chk("divu_starts", div_starts, 1);
    chk("divu_signed", last_div_signed, 0);
    tick();

    // DIV flushed at wait cycle 10, then a stray div_done
    div_delay = 50;
    expect_hl("div_flush", 32'd2, 32'd14, 0, 0);
    issue(3'd2, 32'hFFFF_FF9C, 32'd7, "div_flush");
    chk("div_signed", last_div_signed, 1);
    repeat (9) tick();
    bus.flush = 1; #1;
    chk("div_abort_comb", bus.div_abort, 1);
    tick();
    bus.flush = 0;
    chk("div_flush_busy", bus.busy, 0);
    chk("div_flush_ready", bus.op_ready, 1);
    stray_done = 1;
    tick();
    stray_done = 0;
    tick();
    chk("div_flush_aborts", aborts, 1);
    pop_check();

    // Flush coincident with div_done
    div_delay = 4;
    expect_hl("done_flush", 32'd2, 32'd14, 0, 0);
    issue(3'd3, 32'd50, 32'd5, "done_flush");
    repeat (3) tick();
    bus.flush = 1; #1;
    chk("done_flush_abort", bus.div_abort, 1);
    tick();
    bus.flush = 0;
    chk("done_flush_busy", bus.busy, 0);
    chk("done_flush_aborts", aborts, 2);
    pop_check();

    // DIV by zero: no launch, single-cycle completion
    ds = div_starts;
    expect_hl("div0", 32'd2, 32'd14, 0, 0);
    issue(3'd2, 32'd5, 32'd0, "div0");
    chk("div0_no_start", div_starts, ds);
    chk("div0_ready", bus.op_ready, 1);
    chk("div0_busy", bus.busy, 0);
    pop_check();

    // Flush in IDLE blocks an MTHI; reserved type is a no-op
    expect_hl("idle_flush", 32'd2, 32'd14, 0, 0);
    bus.flush = 1;
    issue(3'd4, 32'hFFFF_0000, 32'd0, "idle_flush");
    bus.flush = 0;
    pop_check();
    expect_hl("type7", 32'd2, 32'd14, 0, 0);
    issue(3'd7, 32'h5555_AAAA, 32'd1, "type7");
    chk("type7_busy", bus.busy, 0);
    pop_check();

    // MUL flushed mid-flight: no result pulse
    rp = res_pulses;
    expect_hl("mul_flush", 32'd2, 32'd14, 0, 0);
    issue(3'd6, 32'd3, 32'd3, "mul_flush");
    bus.flush = 1;
    tick();
    bus.flush = 0;
    chk("mul_flush_busy", bus.busy, 0);
    repeat (4) tick();
    chk("mul_flush_no_res", res_pulses, rp);
    pop_check();

    // Clr during MUL_WAIT
    expect_hl("clr_mid", 32'd0, 32'd0, 0, 0);
    issue(3'd0, 32'd5, 32'd5, "clr_mid");
    tick();
    Clr = 1; #1;
    chk("clr_busy", bus.busy, 0);
    chk("clr_hilo", {bus.hi, bus.lo}, 64'd0);
    tick();
    Clr = 0;
    repeat (5) tick();
    chk("clr_no_res", res_pulses, rp);
    pop_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
